// File: rtl/store_merge_unit.sv
// store_merge_unit: executes SB/SH/SW against word-wide memory; SB/SH do read-modify-write of the low lane.
module store_merge_unit #(
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
    localparam logic [2:0] CNT_INIT = 3'(MEM_RD_LATENCY - 1);
    state_t      state_q, state_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] addr_q, addr_d, reg_q, reg_d, wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
    // mem_rdata is only looked at on the last WAIT cycle, where it is merged straight into the write word
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                ctrl_d  = store_ctrl;
                addr_d  = addr;
                reg_d   = reg_data;
                wdata_d = reg_data;
                state_d = store_ctrl == 2'd0 ? ERR : store_ctrl == 2'd3 ? WRITE : READ;
            end
            READ: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: if (cnt_q == 3'd0) begin
                wdata_d = ctrl_q == 2'd1 ? {mem_rdata[31:8], reg_q[7:0]} : {mem_rdata[31:16], reg_q[15:0]};
                state_d = WRITE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = state_q == WRITE;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign err       = state_q == ERR;
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed vectors against two instances (read latency 1 and 3) driven in lockstep.
module tb_store_merge_unit;
    localparam logic [31:0] JUNK = 32'hBAD0_0BAD;
    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] rdat;
        logic [31:0] mem;
        logic [31:0] exp;
    } vec_t;
    logic        clk = 0, reset = 1, start = 0;
    logic [1:0]  ctrl = 0;
    logic [31:0] addr = 0, rdat = 0, rd1 = JUNK, rd3 = JUNK;
    logic [31:0] ma1, ma3, mw1, mw3;
    logic [1:0]  wr, bz, dn, er;
    int          n_cmp = 0, n_bad = 0;
    vec_t        tbl[7];
    always #5 clk = ~clk;
    store_merge_unit #(.MEM_RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .store_ctrl(ctrl), .addr(addr), .reg_data(rdat),
        .mem_rdata(rd1), .mem_addr(ma1), .mem_wdata(mw1), .mem_wr(wr[0]), .busy(bz[0]), .done(dn[0]), .err(er[0])
    );
    store_merge_unit #(.MEM_RD_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .store_ctrl(ctrl), .addr(addr), .reg_data(rdat),
        .mem_rdata(rd3), .mem_addr(ma3), .mem_wdata(mw3), .mem_wr(wr[1]), .busy(bz[1]), .done(dn[1]), .err(er[1])
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Memory read data is valid only during the last WAIT cycle of each instance (cycle 1+L after start).
    task automatic run(input vec_t v);
        int wc[2], wcy[2], dc[2], dcy[2], ec[2], ecy[2], ic[2], ov[2];
        logic [31:0] wd[2], wa[2];
        for (int i = 0; i < 2; i++) begin
            wc[i] = 0; wcy[i] = 0; dc[i] = 0; dcy[i] = 0; ec[i] = 0; ecy[i] = 0; ic[i] = 0; ov[i] = 0;
            wd[i] = 0; wa[i] = 0;
        end
        @(negedge clk);
        start = 1; ctrl = v.ctrl; addr = v.addr; rdat = v.rdat; rd1 = JUNK; rd3 = JUNK;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (wr[i]) begin wc[i]++; wcy[i] = c; wd[i] = i ? mw3 : mw1; wa[i] = i ? ma3 : ma1; end
                if (dn[i]) begin dc[i]++; dcy[i] = c; end
                if (er[i]) begin ec[i]++; ecy[i] = c; end
                if (!bz[i] && ic[i] == 0) ic[i] = c;
                if (int'(wr[i]) + int'(dn[i]) + int'(er[i]) > 1) ov[i]++;
            end
            start = (c == 2 && v.ctrl != 2'd0);
            if (c == 1) begin ctrl = 2'd3; addr = 32'hFFF0; rdat = 32'h5555_5555; end
            rd1 = (c == 2) ? v.mem : JUNK;
            rd3 = (c == 4) ? v.mem : JUNK;
        end
        start = 0;
        for (int i = 0; i < 2; i++) begin
            int l, ed;
            bit legal;
            string sfx;
            l = i ? 3 : 1;
            sfx = i ? "_L3" : "_L1";
            legal = v.ctrl != 2'd0;
            ed = v.ctrl == 2'd3 ? 2 : 3 + l;
            chk({"wr_count", sfx}, wc[i], legal ? 1 : 0);
            chk({"done_count", sfx}, dc[i], legal ? 1 : 0);
            chk({"err_count", sfx}, ec[i], legal ? 0 : 1);
            chk({"overlap", sfx}, ov[i], 0);
            chk({"idle_cycle", sfx}, ic[i], legal ? ed + 1 : 2);
            if (legal) begin
                chk({"wr_cycle", sfx}, wcy[i], ed - 1);
                chk({"done_cycle", sfx}, dcy[i], ed);
                chk({"wdata", sfx}, wd[i], v.exp);
                chk({"waddr", sfx}, wa[i], v.addr);
            end else begin
                chk({"err_cycle", sfx}, ecy[i], 1);
            end
        end
    endtask
    task automatic rst_seq(input logic [1:0] sc, input int rc, input logic [1:0] wmask);
        int bad = 0;
        @(negedge clk);
        start = 1; ctrl = sc; addr = 32'h300; rdat = 32'h1234_5678;
        for (int c = 1; c <= rc + 8; c++) begin
            @(negedge clk);
            if (c == rc) chk("pre_reset_wr", wr, wmask);
            if (c == rc + 1) begin
                chk("rst_busy", bz, 0);
                chk("rst_wr", wr, 0);
                chk("rst_done", dn, 0);
                chk("rst_err", er, 0);
                chk("rst_addr_L1", ma1, 0);
                chk("rst_addr_L3", ma3, 0);
                chk("rst_wdata_L1", mw1, 0);
                chk("rst_wdata_L3", mw3, 0);
            end
            if (c > rc && (|dn || |wr || |er)) bad++;
            start = 0;
            reset = (c == rc);
            rd1 = (c == 2) ? 32'hCAFE_0000 : JUNK;
            rd3 = (c == 4) ? 32'hCAFE_0000 : JUNK;
        end
        chk("post_reset_quiet", bad, 0);
    endtask
    initial begin
        tbl[0] = '{2'd3, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[1] = '{2'd1, 32'h0000_0100, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33DD};
        tbl[2] = '{2'd2, 32'h0000_0200, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF};
        tbl[3] = '{2'd0, 32'h0000_0300, 32'h0BAD_0BAD, 32'h1111_1111, 32'h0000_0000};
        tbl[4] = '{2'd1, 32'h0000_0404, 32'hFFFF_FF00, 32'hCAFE_F00D, 32'hCAFE_F000};
        tbl[5] = '{2'd2, 32'h0000_0508, 32'h1234_5678, 32'hA5A5_A5A5, 32'hA5A5_5678};
        tbl[6] = '{2'd3, 32'h0000_060C, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        reset = 1; start = 1; ctrl = 2'd3; addr = 32'h123; rdat = 32'h456;
        repeat (3) @(negedge clk);
        chk("reset_busy", bz, 0);
        chk("reset_wr", wr, 0);
        chk("reset_done", dn, 0);
        chk("reset_err", er, 0);
        chk("reset_addr", ma1, 0);
        chk("reset_wdata", mw3, 0);
        reset = 0; start = 0;
        @(negedge clk);
        chk("idle_after_reset", bz, 0);
        for (int k = 0; k < 7; k++) run(tbl[k]);
        @(negedge clk);
        start = 1; ctrl = 2'd3; addr = 32'h80; rdat = 32'h0000_1111;
        @(negedge clk);
        chk("b2b_wr1", wr, 2'b11);
        chk("b2b_wdata1", mw1, 32'h0000_1111);
        start = 0;
        @(negedge clk);
        chk("b2b_done1", dn, 2'b11);
        @(negedge clk);
        chk("b2b_idle", bz, 2'b00);
        start = 1; addr = 32'h84; rdat = 32'h0000_2222;
        @(negedge clk);
        chk("b2b_wr2", wr, 2'b11);
        chk("b2b_wdata2", mw3, 32'h0000_2222);
        chk("b2b_addr2", ma3, 32'h84);
        start = 0;
        @(negedge clk);
        chk("b2b_done2", dn, 2'b11);
        rst_seq(2'd2, 2, 2'b00);
        rst_seq(2'd1, 3, 2'b01);
        rst_seq(2'd1, 5, 2'b10);
        rst_seq(2'd3, 1, 2'b11);
        run(tbl[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
